// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder
//   Entry-lane front end for the parking lot. Two infrared beams (outer A,
//   inner B) are synchronised, debounced and fed to a crossing-sequence FSM
//   that emits one-cycle pulses for completed entries (x), completed exits
//   (EXIT) and aborted or illegal sequences (ERR).
//
// Ports
//   CLK      : system clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   A_RAW    : outer beam, 1 = broken, asynchronous to CLK
//   B_RAW    : inner beam, 1 = broken, asynchronous to CLK
//   x        : one-cycle pulse per completed entry (feeds occupancy FSM)
//   EXIT     : one-cycle pulse per completed exit
//   ERR      : one-cycle pulse on timeout or illegal sequence
//   BUSY     : high whenever the FSM is outside IDLE
//   PHASE    : current FSM state code, for debug
module gate_sensor_decoder #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       A_RAW,
    input  logic       B_RAW,
    output logic       x,
    output logic       EXIT,
    output logic       ERR,
    output logic       BUSY,
    output logic [2:0] PHASE
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IN1  = 3'd1,
        IN2  = 3'd2,
        IN3  = 3'd3,
        BAD  = 3'd4,
        OUT1 = 3'd5,
        OUT2 = 3'd6,
        OUT3 = 3'd7
    } phase_e;

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // Channel index 0 is beam A, index 1 is beam B.
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] deb_q,   deb_d;
    logic [3:0] cnt_q [2];
    logic [3:0] cnt_d [2];

    phase_e     state_q, state_d;
    logic [7:0] tmo_q,   tmo_d;
    logic       rearm_q, rearm_d;
    logic       x_q,     x_d;
    logic       exit_q,  exit_d;
    logic       err_q,   err_d;

    logic a, b;

    // Two-flop synchronisers, then an independent debounce counter per beam.
    // A level is accepted only after it has disagreed with the debounced
    // value for DEBOUNCE consecutive cycles.
    always_comb begin
        sync1_d = {B_RAW, A_RAW};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = 4'd0;
            if (sync2_q[ch] != deb_q[ch]) begin
                if (cnt_q[ch] == DEB_LAST) begin
                    deb_d[ch] = sync2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 4'd1;
                end
            end
        end
    end

    assign a = deb_q[0];
    assign b = deb_q[1];

    // Crossing FSM. A timeout overrides whatever the sensors say this cycle
    // and leaves the FSM parked in IDLE until both beams have been clear,
    // so a car stuck in the beam cannot immediately start a fresh sequence.
    always_comb begin
        state_d = state_q;
        rearm_d = rearm_q;
        x_d     = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q + 8'd1;

        if (state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            rearm_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rearm_q) begin
                        if (!a && !b) rearm_d = 1'b0;
                    end else begin
                        case ({a, b})
                            2'b10:   state_d = IN1;
                            2'b01:   state_d = OUT1;
                            2'b11:   err_d   = 1'b1;
                            default: ;
                        endcase
                    end
                end
                IN1: begin
                    case ({a, b})
                        2'b11:   state_d = IN2;
                        2'b00:   state_d = IDLE;
                        2'b01:   begin state_d = IDLE; err_d = 1'b1; end
                        default: ;
                    endcase
                end
                IN2: begin
                    case ({a, b})
                        2'b01:   state_d = IN3;
                        2'b10:   state_d = IN1;
                        2'b00:   begin state_d = IDLE; err_d = 1'b1; end
                        default: ;
                    endcase
                end
                IN3: begin
                    case ({a, b})
                        2'b00:   begin state_d = IDLE; x_d = 1'b1; end
                        2'b11:   state_d = IN2;
                        2'b10:   begin state_d = IDLE; err_d = 1'b1; end
                        default: ;
                    endcase
                end
                OUT1: begin
                    case ({a, b})
                        2'b11:   state_d = OUT2;
                        2'b00:   state_d = IDLE;
                        2'b10:   begin state_d = IDLE; err_d = 1'b1; end
                        default: ;
                    endcase
                end
                OUT2: begin
                    case ({a, b})
                        2'b10:   state_d = OUT3;
                        2'b01:   state_d = OUT1;
                        2'b00:   begin state_d = IDLE; err_d = 1'b1; end
                        default: ;
                    endcase
                end
                OUT3: begin
                    case ({a, b})
                        2'b00:   begin state_d = IDLE; exit_d = 1'b1; end
                        2'b11:   state_d = OUT2;
                        2'b01:   begin state_d = IDLE; err_d = 1'b1; end
                        default: ;
                    endcase
                end
                default: begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            endcase
        end

        // The timeout measures time spent in one non-idle state.
        if (state_d != state_q || state_q == IDLE) tmo_d = 8'd0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            deb_q    <= 2'b00;
            cnt_q[0] <= 4'd0;
            cnt_q[1] <= 4'd0;
            state_q  <= IDLE;
            tmo_q    <= 8'd0;
            rearm_q  <= 1'b0;
            x_q      <= 1'b0;
            exit_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            rearm_q  <= rearm_d;
            x_q      <= x_d;
            exit_q   <= exit_d;
            err_q    <= err_d;
        end
    end

    assign x     = x_q;
    assign EXIT  = exit_q;
    assign ERR   = err_q;
    assign BUSY  = (state_q != IDLE);
    assign PHASE = state_q;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb_gate_sensor_decoder
//   Drives gate_sensor_decoder with directed crossings and random beam
//   patterns, comparing every cycle against a behavioural model that works
//   from the raw-input history and a step/direction view of a crossing.
module tb_gate_sensor_decoder;

    localparam int DEB = 4;
    localparam int TMO = 64;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       A_RAW = 1'b0;
    logic       B_RAW = 1'b0;
    logic       x, EXIT, ERR, BUSY;
    logic [2:0] PHASE;

    int checkCount = 0;
    int errorCount = 0;
    int xPulses = 0, exitPulses = 0, errPulses = 0;
    bit nonIdleSeen = 0;
    bit checkEnable = 1;

    gate_sensor_decoder #(.DEBOUNCE(DEB), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .A_RAW(A_RAW), .B_RAW(B_RAW),
        .x(x), .EXIT(EXIT), .ERR(ERR), .BUSY(BUSY), .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw samples captured at each rising edge; index 0 is the newest.
    bit histA [0:DEB+1];
    bit histB [0:DEB+1];
    bit mDebA = 0, mDebB = 0;
    int mSide = 0;          // 0 = entering, 1 = leaving
    int mStep = 0;          // 0 = idle, 1..3 = progress through the crossing
    bit mBlocked = 0;
    int mEdge = 0, mEntryEdge = 0;
    bit mX = 0, mExit = 0, mErr = 0;

    // Crossing progress: pattern p is 0 none, 1 outer only, 2 both, 3 inner only.
    // Moving one step forward or back is legal; finishing from step 3 with
    // both beams clear completes; anything else is an error.
    function automatic int nextStep(input int s, input int p, output int ev);
        ev = 0;
        if (p == s) return s;
        if (p == s - 1) return s - 1;
        if (s < 3 && p == s + 1) return s + 1;
        if (s == 3 && p == 0) begin ev = 1; return 0; end
        ev = 2;
        return 0;
    endfunction

    function automatic int patternOf(input bit outer, input bit inner);
        if (!outer && !inner) return 0;
        if (outer && !inner) return 1;
        if (outer && inner) return 2;
        return 3;
    endfunction

    function automatic int modelPhase();
        if (mStep == 0) return 0;
        return (mSide == 1) ? 4 + mStep : mStep;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i <= DEB + 1; i++) begin histA[i] = 0; histB[i] = 0; end
            mDebA = 0; mDebB = 0; mSide = 0; mStep = 0; mBlocked = 0;
            mEdge = 0; mEntryEdge = 0; mX = 0; mExit = 0; mErr = 0;
        end else begin
            int prevStep, prevSide, ev, ns;
            bit flipA, flipB;
            mEdge++;
            mX = 0; mExit = 0; mErr = 0;
            prevStep = mStep;
            prevSide = mSide;
            if (mStep != 0 && (mEdge - mEntryEdge) == TMO) begin
                mStep = 0; mErr = 1; mBlocked = 1;
            end else if (mStep == 0) begin
                if (mBlocked) begin
                    if (!mDebA && !mDebB) mBlocked = 0;
                end else if (mDebA && mDebB) begin
                    mErr = 1;
                end else if (mDebA) begin
                    mSide = 0; mStep = 1;
                end else if (mDebB) begin
                    mSide = 1; mStep = 1;
                end
            end else begin
                if (mSide == 0) ns = nextStep(mStep, patternOf(mDebA, mDebB), ev);
                else            ns = nextStep(mStep, patternOf(mDebB, mDebA), ev);
                mStep = ns;
                if (ev == 1) begin
                    if (mSide == 0) mX = 1; else mExit = 1;
                end else if (ev == 2) begin
                    mErr = 1;
                end
            end
            if (mStep != prevStep || (mStep != 0 && mSide != prevSide)) mEntryEdge = mEdge;

            for (int i = DEB + 1; i > 0; i--) begin histA[i] = histA[i-1]; histB[i] = histB[i-1]; end
            histA[0] = A_RAW;
            histB[0] = B_RAW;
            // A debounced level flips once the synchronised value (raw delayed
            // by two edges) has disagreed with it for DEB consecutive edges.
            flipA = 1; flipB = 1;
            for (int i = 2; i <= DEB + 1; i++) begin
                if (histA[i] == mDebA) flipA = 0;
                if (histB[i] == mDebB) flipB = 0;
            end
            if (flipA) mDebA = ~mDebA;
            if (flipB) mDebB = ~mDebB;
        end
    end

    // Per-cycle comparison of all outputs against the model, plus pulse tallies.
    always @(negedge CLK) begin
        if (checkEnable) begin
            checkOutput("outs", {x, EXIT, ERR, BUSY, PHASE},
                        {mX, mExit, mErr, (modelPhase() != 0), 3'(modelPhase())});
            checkOutput("onehot", int'(x) + int'(EXIT) + int'(ERR) <= 1, 1);
        end
        xPulses    += int'(x);
        exitPulses += int'(EXIT);
        errPulses  += int'(ERR);
        if (BUSY) nonIdleSeen = 1;
    end

    // Hold both beams at the given levels for the given number of cycles.
    task automatic applyStimulus(input bit a, input bit b, input int cycles);
        @(negedge CLK);
        A_RAW = a;
        B_RAW = b;
        repeat (cycles - 1) @(negedge CLK);
    endtask

    // First three stages of a crossing; the caller clears the beams.
    task automatic runCrossing(input bit leaving, input int h1, input int h2, input int h3);
        if (!leaving) begin
            applyStimulus(1, 0, h1); applyStimulus(1, 1, h2); applyStimulus(0, 1, h3);
        end else begin
            applyStimulus(0, 1, h1); applyStimulus(1, 1, h2); applyStimulus(1, 0, h3);
        end
    endtask

    task automatic pulseReset(input int cycles);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        repeat (cycles) @(negedge CLK);
        #2 RESET_N = 1'b1;
    endtask

    initial begin
        int x0, e0, r0, lat, t0, errAt, errInWin;
        bit found;

        $display("[TB] reset");
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b1;
        checkOutput("resetOuts", {x, EXIT, ERR, BUSY, PHASE}, 0);
        applyStimulus(0, 0, 20);
        checkOutput("resetQuiet", xPulses + exitPulses + errPulses, 0);

        $display("[TB] entry");
        x0 = xPulses; e0 = exitPulses; r0 = errPulses;
        runCrossing(0, 10, 10, 10);
        checkOutput("entryIn3", PHASE, 3);
        @(negedge CLK);
        A_RAW = 0; B_RAW = 0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (x && lat < 0) lat = i;
        end
        checkOutput("entryLatency", lat, 7);
        checkOutput("entryX", xPulses - x0, 1);
        checkOutput("entryNoOther", (exitPulses - e0) + (errPulses - r0), 0);

        $display("[TB] exit");
        x0 = xPulses; e0 = exitPulses;
        runCrossing(1, 10, 10, 10);
        checkOutput("exitOut3", PHASE, 7);
        applyStimulus(0, 0, 15);
        checkOutput("exitPulse", exitPulses - e0, 1);
        checkOutput("exitNoX", xPulses - x0, 0);

        $display("[TB] glitch rejection");
        nonIdleSeen = 0;
        x0 = xPulses + exitPulses + errPulses;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 2);
            applyStimulus(0, 0, 6);
        end
        checkOutput("glitchIdle", nonIdleSeen, 0);
        applyStimulus(1, 0, 6);
        applyStimulus(0, 0, 12);
        checkOutput("shortPulseBusy", nonIdleSeen, 1);
        checkOutput("shortPulseQuiet", xPulses + exitPulses + errPulses - x0, 0);

        $display("[TB] timeout");
        @(negedge CLK);
        A_RAW = 1; B_RAW = 0;
        found = 0; t0 = 0; errAt = -1000; errInWin = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!found && PHASE == 3'd1) begin found = 1; t0 = i; end
            if (ERR) begin errInWin++; if (errAt < 0) errAt = i; end
        end
        checkOutput("tmoLatency", errAt - t0, TMO);
        checkOutput("tmoOnce", errInWin, 1);
        checkOutput("tmoNoReentry", PHASE, 0);
        applyStimulus(0, 0, 10);
        x0 = xPulses;
        runCrossing(0, 10, 10, 10);
        applyStimulus(0, 0, 12);
        checkOutput("tmoRecoverX", xPulses - x0, 1);

        $display("[TB] reset mid-sequence");
        x0 = xPulses;
        runCrossing(0, 10, 10, 10);
        checkOutput("midIn3", PHASE, 3);
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1 checkOutput("midAsync", {x, EXIT, ERR, BUSY, PHASE}, 0);
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        applyStimulus(0, 0, 20);
        checkOutput("midNoX", xPulses - x0, 0);

        $display("[TB] random");
        for (int s = 0; s < 250; s++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 10) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              $urandom_range(1, 14));
            end else if (r < 19) begin
                runCrossing(1'($urandom_range(0, 1)), $urandom_range(4, 16),
                            $urandom_range(4, 16), $urandom_range(4, 16));
                applyStimulus(0, 0, $urandom_range(4, 16));
            end else begin
                pulseReset($urandom_range(1, 3));
            end
        end
        applyStimulus(0, 0, 20);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
